// File: rtl/bcd_stopwatch_scan.sv
// bcd_stopwatch_scan: MM:SS BCD stopwatch driven by the slow divider clock,
// scanned onto a 4-digit active-low seven-segment display.
module bcd_stopwatch_scan #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz_in,
    input  logic [1:0] clk_ctl,
    input  logic       start_stop,
    input  logic       clear,
    output logic [7:0] ssd,
    output logic [3:0] ssd_ctl,
    output logic       running,
    output logic       wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);
    state_t     state_q, state_d;
    logic       s1_q, s2_q, s3_q;
    logic [3:0] s0_q, s1d_q, m0_q, m1_q;
    logic [3:0] s0_d, s1d_d, m0_d, m1_d;
    logic [7:0] ssd_q, ssd_d, seg;
    logic [3:0] ssd_ctl_q, ssd_ctl_d, dig;
    logic       running_q, wrap_q, wrap_d;
    logic       tick, count, sec_c, min_c, min_w;
    always_comb begin
        tick    = s2_q & ~s3_q;
        count   = tick & (state_q == RUN) & ~clear;
        sec_c   = s0_q == 4'd9;
        min_c   = sec_c & (s1d_q == 4'd5);
        min_w   = min_c & (m1_q == MAX_M1) & (m0_q == MAX_M0);
        state_d = clear ? IDLE : start_stop ? ((state_q == RUN) ? PAUSE : RUN) : state_q;
        s0_d    = s0_q;
        s1d_d   = s1d_q;
        m0_d    = m0_q;
        m1_d    = m1_q;
        if (clear) begin
            s0_d  = '0;
            s1d_d = '0;
            m0_d  = '0;
            m1_d  = '0;
        end else if (count) begin
            s0_d = sec_c ? 4'd0 : s0_q + 4'd1;
            if (sec_c)
                s1d_d = (s1d_q == 4'd5) ? 4'd0 : s1d_q + 4'd1;
            if (min_c) begin
                m0_d = (min_w || m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
                m1_d = min_w ? 4'd0 : (m0_q == 4'd9) ? m1_q + 4'd1 : m1_q;
            end
        end
        wrap_d = count & min_w;
    end
    always_comb begin
        dig = clk_ctl == 2'd0 ? s0_q : clk_ctl == 2'd1 ? s1d_q : clk_ctl == 2'd2 ? m0_q : m1_q;
        case (dig)
            4'd0:    seg = 8'b00000011;
            4'd1:    seg = 8'b10011111;
            4'd2:    seg = 8'b00100101;
            4'd3:    seg = 8'b00001101;
            4'd4:    seg = 8'b10011001;
            4'd5:    seg = 8'b01001001;
            4'd6:    seg = 8'b01000001;
            4'd7:    seg = 8'b00011111;
            4'd8:    seg = 8'b00000001;
            4'd9:    seg = 8'b00001001;
            default: seg = 8'b11111111;
        endcase
        // dp marks the MM.SS separator on the minutes-ones digit
        ssd_d     = {seg[7:1], seg[0] & (clk_ctl != 2'd2)};
        ssd_ctl_d = ~(4'b0001 << clk_ctl);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            {s1_q, s2_q, s3_q} <= '0;
            {s0_q, s1d_q, m0_q, m1_q} <= '0;
            ssd_q     <= 8'hFF;
            ssd_ctl_q <= 4'hF;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            {s1_q, s2_q, s3_q} <= {clk_1hz_in, s1_q, s2_q};
            {s0_q, s1d_q, m0_q, m1_q} <= {s0_d, s1d_d, m0_d, m1_d};
            ssd_q     <= ssd_d;
            ssd_ctl_q <= ssd_ctl_d;
            running_q <= state_d == RUN;
            wrap_q    <= wrap_d;
        end
    end
    assign ssd     = ssd_q;
    assign ssd_ctl = ssd_ctl_q;
    assign running = running_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch_scan.sv
// tb_bcd_stopwatch_scan: random and scenario stimulus against a seconds-count
// reference model; expected outputs are queued and checked by a monitor.
module tb_bcd_stopwatch_scan;
    localparam int MAX_MIN = 59;
    localparam int MAXS = (MAX_MIN + 1) * 60;
    logic       clk = 0, rst = 1, clk_1hz_in = 0, start_stop = 0, clear = 0;
    logic [1:0] clk_ctl = 0;
    logic [7:0] ssd;
    logic [3:0] ssd_ctl;
    logic       running, wrap;
    bcd_stopwatch_scan #(.MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .rst(rst), .clk_1hz_in(clk_1hz_in), .clk_ctl(clk_ctl),
        .start_stop(start_stop), .clear(clear), .ssd(ssd), .ssd_ctl(ssd_ctl),
        .running(running), .wrap(wrap)
    );
    always #5 clk = ~clk;
    logic [7:0] segtab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                                8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};
    logic [3:0] ctltab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [13:0] expq [$];
    int compared = 0, mismatched = 0;
    int st = 0, secs = 0;  // st: 0 idle, 1 run, 2 pause; secs: elapsed seconds
    bit h1 = 0, h2 = 0, h3 = 0;  // clk_1hz_in samples at the last three edges
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            logic [13:0] e, a;
            e = expq.pop_front();
            a = {ssd, ssd_ctl, running, wrap};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL outputs t=%0t: got ssd=%b ctl=%b run=%b wrap=%b, want ssd=%b ctl=%b run=%b wrap=%b",
                         $time, a[13:6], a[5:2], a[1], a[0], e[13:6], e[5:2], e[1], e[0]);
            end
        end
    end
    task automatic model_edge();
        bit tick, cnt, wr;
        int old, d;
        logic [7:0] s;
        if (rst) begin
            st = 0; secs = 0; h1 = 0; h2 = 0; h3 = 0;
            expq.push_back({8'hFF, 4'hF, 1'b0, 1'b0});
            return;
        end
        tick = h2 && !h3;
        cnt  = tick && st == 1 && !clear;
        old  = secs;
        wr   = cnt && old == MAXS - 1;
        if (cnt) secs = (secs + 1) % MAXS;
        if (clear) secs = 0;
        st = clear ? 0 : start_stop ? (st == 1 ? 2 : 1) : st;
        h3 = h2; h2 = h1; h1 = clk_1hz_in;
        case (clk_ctl)
            2'd0: d = (old % 60) % 10;
            2'd1: d = (old % 60) / 10;
            2'd2: d = (old / 60) % 10;
            default: d = (old / 60) / 10;
        endcase
        s = segtab[d];
        if (clk_ctl == 2'd2) s[0] = 1'b0;
        expq.push_back({s, ctltab[clk_ctl], st == 1, wr});
    endtask
    task automatic cyc(input bit c1, input bit ss = 0, input bit clr = 0, input bit r = 0);
        clk_1hz_in = c1; start_stop = ss; clear = clr; rst = r;
        clk_ctl = 2'($urandom_range(0, 3));
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1); cyc(1); cyc(0); cyc(0);
        end
    endtask
    task automatic tick_with_ss();
        cyc(1); cyc(1); cyc(1, 1); cyc(0); cyc(0);
    endtask
    initial begin
        int ph, v;
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            clk_ctl = 2'(i); rst = 0; clk_1hz_in = 0; start_stop = 0; clear = 0;
            @(posedge clk); model_edge(); #1;
        end
        cyc(0, 1); tk(75); cyc(0, 1); tk(10); cyc(0, 1); tk(5);
        cyc(0, 0, 1); cyc(0, 1); tk(3598); tk(3);
        cyc(0, 0, 1); cyc(0, 1); tk(187); cyc(0, 1, 1); tk(5);
        cyc(0, 1); tk(9); tick_with_ss(); tk(2); tick_with_ss(); tk(2);
        cyc(0, 0, 1); cyc(0, 1); tk(754); cyc(1); cyc(1);
        cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1); cyc(1); cyc(1); cyc(0); cyc(0); tk(4);
        cyc(0, 1); tk(3);
        ph = 0; v = 0;
        for (int i = 0; i < 4000; i++) begin
            if (ph == 0) begin v = !v; ph = $urandom_range(2, 5); end
            ph--;
            cyc(v[0], $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                $urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected outputs never compared, want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
